// File: rtl/mem_arbiter.sv
// Shares the single-ported data RAM between instruction fetch and load/store, data-first with a bounded streak.
// Latency 3 cycles grant-to-ack, one access per 4 cycles; a requester is held off simply by not being granted.
module mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_DATA_STREAK = 3
) (
  input  logic              clk,
  input  logic              init,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t        state;
  logic          owner_data;
  logic          op_we;
  logic [SW-1:0] streak;
  logic          grant_d;
  logic          grant_f;

  // Fetch only overrides a pending data request once the streak has saturated.
  always_comb begin
    grant_d = d_req && (!f_req || (streak != SW'(MAX_DATA_STREAK)));
    grant_f = f_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      op_we      <= 1'b0;
      streak     <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_f) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner_data <= grant_d;
            op_we      <= grant_d && d_we;
            mem_addr   <= grant_d ? d_addr : f_addr;
            mem_re     <= grant_f || (grant_d && !d_we);
            mem_we     <= grant_d && d_we;
            if (grant_d) begin
              mem_wdata <= d_wdata;
            end
            if (grant_d && f_req) begin
              if (streak != SW'(MAX_DATA_STREAK)) begin
                streak <= streak + 1'b1;
              end
            end else begin
              streak <= '0;
            end
          end
        end
        ACCESS: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (!op_we) begin
            if (owner_data) begin
              d_rdata <= mem_rdata;
            end else begin
              f_rdata <= mem_rdata;
            end
          end
          f_ack <= !owner_data;
          d_ack <= owner_data;
          state <= ACK;
        end
        ACK: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle compare, plus directed scenarios.
module tb_mem_arbiter;
  localparam int MAXS = 3;

  logic        clk = 1'b0;
  logic        init = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .init(init),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pre(input int i);
    if (i == 16'h0010) return 16'h01A5;
    if (i == 16'h0050) return 16'h5555;
    return 16'(i * 3 + 16'h0100);
  endfunction

  // RAM the DUT talks to: read data appears the cycle after mem_re.
  logic [15:0] ram [256];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= pre(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
  end

  // Reference model: one access in flight, tracked by cycles since its grant.
  logic [15:0] shadow [256];
  bit          sh_loaded = 1'b0;
  int          age = -1;
  int          m_streak = 0;
  bit          m_data = 1'b0;
  bit          m_we = 1'b0;
  bit          m_on = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] e_addr = '0;
  logic [15:0] e_wdata = '0;
  logic [15:0] e_f_rdata = '0;
  logic [15:0] e_d_rdata = '0;

  always @(posedge clk) begin
    if (!sh_loaded) begin
      for (int i = 0; i < 256; i++) shadow[i] <= pre(i);
      sh_loaded <= 1'b1;
    end else if (age == 1 && m_we) begin
      shadow[m_addr[7:0]] <= m_wdata;
    end
    if (init) begin
      age = -1; m_streak = 0; m_on = 1'b1;
      e_addr = '0; e_wdata = '0; e_f_rdata = '0; e_d_rdata = '0;
    end else if (age < 0) begin
      if (f_req || d_req) begin
        m_data = d_req && !(f_req && m_streak == MAXS);
        if (m_data && f_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else m_streak = 0;
        m_we    = m_data && d_we;
        m_addr  = m_data ? d_addr : f_addr;
        m_wdata = d_wdata;
        e_addr  = m_addr;
        if (m_data) e_wdata = d_wdata;
        age = 1;
      end
    end else begin
      age++;
      if (age == 3 && !m_we) begin
        if (m_data) e_d_rdata = shadow[m_addr[7:0]];
        else        e_f_rdata = shadow[m_addr[7:0]];
      end
      if (age == 4) age = -1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      chk("busy",    32'(busy),    32'(age >= 1));
      chk("mem_re",  32'(mem_re),  32'(age == 1 && !m_we));
      chk("mem_we",  32'(mem_we),  32'(age == 1 && m_we));
      chk("f_ack",   32'(f_ack),   32'(age == 3 && !m_data));
      chk("d_ack",   32'(d_ack),   32'(age == 3 && m_data));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("f_rdata", 32'(f_rdata), 32'(e_f_rdata));
      chk("d_rdata", 32'(d_rdata), 32'(e_d_rdata));
      if (age == 1 && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  string order;
  int    ack_at[$];

  // Hold the chosen requests high until n acks have been seen, logging who was served and when.
  task automatic run_seq(input bit fe, input bit de, input int n);
    int seen = 0;
    int t = 0;
    order = "";
    ack_at.delete();
    f_req = fe;
    d_req = de;
    while (seen < n && t < 200) begin
      step();
      t++;
      if (f_ack) begin order = {order, "F"}; ack_at.push_back(t); seen++; end
      if (d_ack) begin order = {order, "D"}; ack_at.push_back(t); seen++; end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    if (seen < n) chk("seq_timeout", 32'(seen), 32'(n));
  endtask

  task automatic chk_order(input string name, input string want);
    checks++;
    if (order != want) begin
      failures++;
      $display("FAIL %s: got %s want %s", name, order, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    init = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({mem_re, mem_we}), 0);
    chk("rst_acks", 32'({f_ack, d_ack}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'({f_rdata, d_rdata}), 0);

    // Isolated fetch
    f_addr = 16'h0010; f_req = 1'b1;
    step();
    chk("fetch_re_t1", 32'(mem_re), 1);
    chk("fetch_addr_t1", 32'(mem_addr), 32'h0010);
    step();
    chk("fetch_re_t2", 32'(mem_re), 0);
    chk("fetch_ack_t2", 32'(f_ack), 0);
    step();
    chk("fetch_ack_t3", 32'(f_ack), 1);
    chk("fetch_rdata_t3", 32'(f_rdata), 32'h01A5);
    chk("fetch_dack_t3", 32'(d_ack), 0);
    f_req = 1'b0;
    step();
    chk("fetch_ack_t4", 32'(f_ack), 0);
    chk("fetch_hold_t4", 32'(f_rdata), 32'h01A5);

    // Data write then read back
    d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; d_req = 1'b1;
    step();
    chk("wr_we_t1", 32'(mem_we), 1);
    chk("wr_re_t1", 32'(mem_re), 0);
    chk("wr_wdata_t1", 32'(mem_wdata), 32'hBEEF);
    step(); step();
    chk("wr_ack_t3", 32'(d_ack), 1);
    chk("wr_rdata_kept", 32'(d_rdata), 0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    d_req = 1'b1;
    step(); step(); step();
    chk("rd_ack_t3", 32'(d_ack), 1);
    chk("rd_rdata", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0;
    step();

    // Address changes after grant are ignored
    d_addr = 16'h0040; d_req = 1'b1;
    step();
    d_addr = 16'h0050;
    chk("chg_addr_t1", 32'(mem_addr), 32'h0040);
    step();
    chk("chg_addr_t2", 32'(mem_addr), 32'h0040);
    step();
    chk("chg_ack", 32'(d_ack), 1);
    chk("chg_rdata", 32'(d_rdata), 32'hBEEF);
    d_req = 1'b0; d_addr = 16'h0040;
    step();

    // Contention: starvation bound
    run_seq(1'b1, 1'b1, 8);
    chk_order("contend_order", "DDDFDDDF");
    chk("contend_fetch_wait", 32'(ack_at.size() > 3 ? ack_at[3] : -1), 15);
    step();
    run_seq(1'b1, 1'b1, 2);
    chk_order("contend_short", "DD");
    step();

    // Uncontested data clears the streak
    run_seq(1'b0, 1'b1, 5);
    chk_order("uncontested_order", "DDDDD");
    if (ack_at.size() == 5) begin
      chk("uncontested_first", 32'(ack_at[0]), 3);
      for (int i = 1; i < 5; i++) chk("uncontested_gap", 32'(ack_at[i] - ack_at[i-1]), 4);
    end
    step();
    run_seq(1'b1, 1'b1, 4);
    chk_order("after_clear_order", "DDDF");
    step();

    // Reset during CAPTURE of a fetch
    f_addr = 16'h0010; f_req = 1'b1;
    step(); step();
    init = 1'b1; f_req = 1'b0;
    step();
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_ack", 32'({f_ack, d_ack}), 0);
    chk("rst_mid_frdata", 32'(f_rdata), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    init = 1'b0;
    step();
    chk("rst_mid_noack", 32'(f_ack), 0);
    f_req = 1'b1;
    step(); step(); step();
    chk("post_rst_ack", 32'(f_ack), 1);
    chk("post_rst_rdata", 32'(f_rdata), 32'h01A5);
    f_req = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for the single-ported data RAM, shared between the instruction fetch path and the load/store (data) path of the pipelined CPU. Each requester uses a req/ack handshake. The block grants one access at a time, drives the RAM strobes, captures read data and returns it with a one-cycle ack pulse. Data accesses win by default. A streak counter bounds fetch starvation.

## Interface
- ADDR_W, 16, address width of both requesters and the RAM
- DATA_W, 16, data width (fetch uses the low 9 bits of f_rdata)
- MAX_DATA_STREAK, 3, consecutive contested data grants allowed before fetch must win (≥1)

- clk  in  1  system clock; all state updates on rising edge
- init  in  1  reset, synchronous, active-high
- f_req  in  1  fetch read request; held until f_ack
- f_addr  in  ADDR_W  fetch address
- f_ack  out  1  one-cycle pulse; fetch access complete
- f_rdata  out  DATA_W  fetch read data, valid while f_ack=1, held after
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  DATA_W  data read result, valid while d_ack=1 after a read, held after
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_re  out  1  RAM read strobe (registered)
- mem_we  out  1  RAM write strobe (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE → ACCESS → CAPTURE → ACK → IDLE. No other transitions except reset.
- IDLE, grant decision:
  - If only one req is high, grant it.
  - If both are high, grant data unless streak == MAX_DATA_STREAK, in which case grant fetch.
  - If neither is high, stay in IDLE.
- On grant:
  - Latch owner, address, we and wdata.
  - Load mem_addr, mem_re (fetch, or data read) or mem_we (data write), and mem_wdata.
  - Go to ACCESS.
- ACCESS: strobes are asserted for exactly this one cycle. Go to CAPTURE.
- CAPTURE:
  - Strobes are 0.
  - On a read, latch mem_rdata into the owner's rdata register.
  - Go to ACK.
- ACK:
  - The owner's ack is 1 for this cycle only.
  - The other requester's rdata is unchanged.
  - Go to IDLE.
- Writes follow the same sequence. d_rdata keeps its previous value on a write.
- Streak counter, 0..MAX_DATA_STREAK:
  - On a data grant with f_req=1: increment, saturating.
  - On a data grant with f_req=0: clear.
  - On a fetch grant: clear.
  - On reset: clear.
- Requester inputs are sampled only at grant. Later changes before ack are ignored.
- A requester must drop req in the cycle after its ack. The arbiter never samples req during CAPTURE or ACK.
- Reset values: state=IDLE, all ack/strobe/busy outputs 0, mem_addr/mem_wdata/f_rdata/d_rdata 0, streak 0.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No ack is issued for the abandoned access. A write already strobed in ACCESS stays committed in RAM.
- mem_re and mem_we are never high together.
- At most one ack is high in any cycle.

## Timing
- Request seen in IDLE at cycle T:
  - mem strobes high in T+1
  - mem_rdata sampled in T+2
  - ack and rdata valid in T+3
  - IDLE again in T+4
- Latency is 3 cycles from grant to ack. Throughput is one access per 4 cycles.
- busy is 1 in cycles T+1..T+3.
- The earliest next grant is at T+4, using req levels sampled in T+4.

## Test plan
- Isolated fetch: RAM[0x0010]=0x01A5, f_req at T with f_addr=0x0010 → mem_re=1 and mem_addr=0x0010 in T+1 only; f_ack=1 and f_rdata=0x01A5 in T+3 only; d_ack stays 0.
- Data write then read: write 0xBEEF to 0x0040 → mem_we=1 and mem_wdata=0xBEEF in T+1, d_ack in T+3, d_rdata unchanged. Read of 0x0040 issued next → d_rdata=0xBEEF with d_ack.
- Contention and starvation bound: f_req and d_req held continuously, with d_req re-asserted right after each d_ack. With MAX_DATA_STREAK=3 the grant order is D,D,D,F,D,D,D,F…, and each f_ack arrives within 16 cycles of the streak starting.
- Uncontested data: d_req only, 5 back-to-back accesses → grant every 4 cycles. Streak stays 0, so a fetch arriving afterwards still gets 3 data grants ahead of it.
- Reset mid-access: assert init during CAPTURE of a fetch → next cycle all outputs are 0 and state is IDLE. No f_ack appears. A new f_req then completes normally in 3 cycles.
- Input change after grant: change d_addr from 0x0040 to 0x0050 in ACCESS → mem_addr stays 0x0040 and d_rdata returns RAM[0x0040].
